axi_lite_buffer: RTL and testbench

// - Parametrised per-channel buffer between an AXI-Lite master and slave (axi_lite_channel interfaces).
// - Each of the five channels (AW, W, B, AR, R) gets an independently sized FIFO: 0 = wire, 1 = half-rate register, >=2 = full-rate FIFO.
// - Used for timing closure and rate decoupling between fabric and peripherals.
// - Adds an idle indication for clock-gating and reset sequencing.

---
 rtl/axi_common.sv | 15 +
 rtl/axi_lite_channel.sv | 50 +++++
 rtl/axi_fifo_stage.sv | 68 ++++++
 rtl/axi_lite_buffer.sv | 93 +++++++++
 tb/tb_axi_lite_buffer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_common.sv
// Shared AXI definitions: protection and response encodings plus
// helpers for sizing AXI-Lite buffer payloads.
package axi_common;

    typedef logic [2:0] prot_t;
    typedef logic [1:0] resp_t;

    localparam int AXI_LITE_MAX_BUF_DEPTH = 16;

    // W payload is {data, strb}: one strobe bit per data byte.
    function automatic int axi_lite_w_bits(input int data_width);
        return data_width + data_width / 8;
    endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite five-channel bundle; the master modport drives requests, the
// slave modport drives readies and responses.
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn
);
    import axi_common::*;

    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    prot_t                   aw_prot;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid;
    logic                    b_ready;
    resp_t                   b_resp;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    prot_t                   ar_prot;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    resp_t                   r_resp;

    modport master (
        input  clk, rstn,
        output aw_valid, aw_addr, aw_prot, input  aw_ready,
        output w_valid, w_data, w_strb,    input  w_ready,
        input  b_valid, b_resp,            output b_ready,
        output ar_valid, ar_addr, ar_prot, input  ar_ready,
        input  r_valid, r_data, r_resp,    output r_ready
    );

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_addr, aw_prot, output aw_ready,
        input  w_valid, w_data, w_strb,    output w_ready,
        output b_valid, b_resp,            input  b_ready,
        input  ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp,    input  r_ready
    );

endinterface

// File: rtl/axi_fifo_stage.sv
// Generic valid/ready buffer: DEPTH 0 is a wire, DEPTH 1 a half-rate
// register, DEPTH >= 2 a full-rate circular FIFO.
module axi_fifo_stage #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    if (DEPTH == 0) begin : g_wire
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_data  = in_data;
        assign empty     = 1'b1;

        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
    end else begin : g_fifo
        localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int CNT_W = $clog2(DEPTH + 1);
        localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
        localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;
        logic             push;
        logic             pop;

        // Ready looks only at count, so there is no out_ready -> in_ready path.
        assign in_ready  = (count != FULL);
        assign out_valid = (count != '0);
        assign empty     = (count == '0);
        assign out_data  = mem[rd_ptr];
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end

        // NOTE: storage has no reset; count gates every read, so stale entries are never visible.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/axi_lite_buffer.sv
// Per-channel AXI-Lite buffer between an upstream master and a downstream
// slave, with an idle flag for clock gating and reset sequencing.
module axi_lite_buffer
    import axi_common::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 2,
    parameter int B_DEPTH    = 2,
    parameter int AR_DEPTH   = 2,
    parameter int R_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    axi_lite_channel.slave  master,
    axi_lite_channel.master slave,
    output logic            idle
);
    localparam int A_BITS = ADDR_WIDTH + 3;
    localparam int W_BITS = axi_lite_w_bits(DATA_WIDTH);
    localparam int R_BITS = DATA_WIDTH + 2;

    if (AW_DEPTH < 0 || AW_DEPTH > AXI_LITE_MAX_BUF_DEPTH ||
        W_DEPTH  < 0 || W_DEPTH  > AXI_LITE_MAX_BUF_DEPTH ||
        B_DEPTH  < 0 || B_DEPTH  > AXI_LITE_MAX_BUF_DEPTH ||
        AR_DEPTH < 0 || AR_DEPTH > AXI_LITE_MAX_BUF_DEPTH ||
        R_DEPTH  < 0 || R_DEPTH  > AXI_LITE_MAX_BUF_DEPTH) begin : g_bad_depth
        $fatal(1, "axi_lite_buffer: channel depth outside 0..%0d", AXI_LITE_MAX_BUF_DEPTH);
    end

    if (master.ADDR_WIDTH != ADDR_WIDTH || slave.ADDR_WIDTH != ADDR_WIDTH ||
        master.DATA_WIDTH != DATA_WIDTH || slave.DATA_WIDTH != DATA_WIDTH) begin : g_bad_width
        $fatal(1, "axi_lite_buffer: interface widths do not match parameters");
    end

    // The interfaces carry their own clock/reset; this block runs on clk/rst only.
    logic unused_intf;
    assign unused_intf = ^{master.clk, master.rstn, slave.clk, slave.rstn};

    logic [A_BITS-1:0] aw_out;
    logic [W_BITS-1:0] w_out;
    logic [A_BITS-1:0] ar_out;
    logic [R_BITS-1:0] r_out;
    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;

    axi_fifo_stage #(.WIDTH(A_BITS), .DEPTH(AW_DEPTH)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(master.aw_valid), .in_ready(master.aw_ready),
        .in_data({master.aw_addr, master.aw_prot}),
        .out_valid(slave.aw_valid), .out_ready(slave.aw_ready),
        .out_data(aw_out), .empty(aw_empty)
    );
    assign {slave.aw_addr, slave.aw_prot} = aw_out;

    axi_fifo_stage #(.WIDTH(W_BITS), .DEPTH(W_DEPTH)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(master.w_valid), .in_ready(master.w_ready),
        .in_data({master.w_data, master.w_strb}),
        .out_valid(slave.w_valid), .out_ready(slave.w_ready),
        .out_data(w_out), .empty(w_empty)
    );
    assign {slave.w_data, slave.w_strb} = w_out;

    axi_fifo_stage #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(slave.b_valid), .in_ready(slave.b_ready),
        .in_data(slave.b_resp),
        .out_valid(master.b_valid), .out_ready(master.b_ready),
        .out_data(master.b_resp), .empty(b_empty)
    );

    axi_fifo_stage #(.WIDTH(A_BITS), .DEPTH(AR_DEPTH)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(master.ar_valid), .in_ready(master.ar_ready),
        .in_data({master.ar_addr, master.ar_prot}),
        .out_valid(slave.ar_valid), .out_ready(slave.ar_ready),
        .out_data(ar_out), .empty(ar_empty)
    );
    assign {slave.ar_addr, slave.ar_prot} = ar_out;

    axi_fifo_stage #(.WIDTH(R_BITS), .DEPTH(R_DEPTH)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(slave.r_valid), .in_ready(slave.r_ready),
        .in_data({slave.r_data, slave.r_resp}),
        .out_valid(master.r_valid), .out_ready(master.r_ready),
        .out_data(r_out), .empty(r_empty)
    );
    assign {master.r_data, master.r_resp} = r_out;

    assign idle = aw_empty & w_empty & b_empty & ar_empty & r_empty;

endmodule

// File: tb/tb_axi_lite_buffer.sv
// Directed bench for axi_lite_buffer with AW=2, W=3, B=1, AR=0, R=3 deep channels.
module tb_axi_lite_buffer;

    localparam int AW = 48;
    localparam int DW = 64;

    logic clk;
    logic rst;
    logic rstn;
    logic idle;
    int   n_checks = 0;
    int   n_errors = 0;

    assign rstn = ~rst;

    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if (.clk(clk), .rstn(rstn));
    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if (.clk(clk), .rstn(rstn));

    axi_lite_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .AW_DEPTH(2), .W_DEPTH(3), .B_DEPTH(1), .AR_DEPTH(0), .R_DEPTH(3)
    ) dut (
        .clk(clk), .rst(rst), .master(m_if), .slave(s_if), .idle(idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        valid;
        logic [47:0] addr;
        logic [2:0]  prot;
        logic        s_ready;
        logic        exp_valid;
        logic [47:0] exp_addr;
        logic [2:0]  exp_prot;
        logic        exp_ready;
    } ar_vec_t;

    ar_vec_t     ar_tab [4];
    logic [63:0] wd [4];
    logic [7:0]  ws [4];

    initial begin
        int got;
        int cnt;
        int sent;
        int recv;
        logic acc;
        logic push;
        logic pop;

        ar_tab[0] = '{1'b1, 48'h1234_5678_9ABC, 3'b101, 1'b1, 1'b1, 48'h1234_5678_9ABC, 3'b101, 1'b1};
        ar_tab[1] = '{1'b1, 48'hFFFF_0000_0010, 3'b000, 1'b0, 1'b1, 48'hFFFF_0000_0010, 3'b000, 1'b0};
        ar_tab[2] = '{1'b0, 48'h0000_0000_0000, 3'b111, 1'b1, 1'b0, 48'h0000_0000_0000, 3'b111, 1'b1};
        ar_tab[3] = '{1'b1, 48'h0000_0000_0040, 3'b010, 1'b0, 1'b1, 48'h0000_0000_0040, 3'b010, 1'b0};
        wd = '{64'h11, 64'h22, 64'h33, 64'h44};
        ws = '{8'h01, 8'h03, 8'h0F, 8'hFF};

        rst = 1'b1;
        m_if.aw_valid = 1'b0; m_if.aw_addr = '0; m_if.aw_prot = '0;
        m_if.w_valid  = 1'b0; m_if.w_data  = '0; m_if.w_strb  = '0;
        m_if.b_ready  = 1'b1;
        m_if.ar_valid = 1'b0; m_if.ar_addr = '0; m_if.ar_prot = '0;
        m_if.r_ready  = 1'b1;
        s_if.aw_ready = 1'b1; s_if.w_ready = 1'b1; s_if.ar_ready = 1'b1;
        s_if.b_valid  = 1'b0; s_if.b_resp  = '0;
        s_if.r_valid  = 1'b0; s_if.r_data  = '0; s_if.r_resp = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_idle", idle, 1);
        check("rst_aw_ready", m_if.aw_ready, 1);
        check("rst_w_ready", m_if.w_ready, 1);
        check("rst_b_ready", s_if.b_ready, 1);
        check("rst_r_ready", s_if.r_ready, 1);
        check("rst_aw_valid", s_if.aw_valid, 0);
        check("rst_w_valid", s_if.w_valid, 0);
        check("rst_b_valid", m_if.b_valid, 0);
        check("rst_r_valid", m_if.r_valid, 0);
        rst = 1'b0;
        tick();

        // Throughput: 8 back-to-back AW beats through a 2-deep FIFO
        for (int i = 0; i < 8; i++) begin
            m_if.aw_valid = 1'b1;
            m_if.aw_addr  = 48'(i * 8);
            m_if.aw_prot  = 3'(i);
            check("aw_tp_ready", m_if.aw_ready, 1);
            tick();
            check("aw_tp_valid", s_if.aw_valid, 1);
            check("aw_tp_payload", {s_if.aw_addr, s_if.aw_prot}, {48'(i * 8), 3'(i)});
        end
        m_if.aw_valid = 1'b0;
        tick();
        check("aw_tp_drained", s_if.aw_valid, 0);
        check("aw_tp_idle", idle, 1);

        // Backpressure: W FIFO fills at 3, then drains in order
        s_if.w_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_if.w_valid = 1'b1;
            m_if.w_data  = wd[k];
            m_if.w_strb  = ws[k];
            check("w_bp_accept", m_if.w_ready, 1);
            tick();
        end
        m_if.w_data = wd[3];
        m_if.w_strb = ws[3];
        check("w_bp_full", m_if.w_ready, 0);
        check("w_bp_busy", idle, 0);
        check("w_bp_head", s_if.w_data, 64'h11);
        tick();
        check("w_bp_still_full", m_if.w_ready, 0);
        check("w_bp_held", {s_if.w_valid, s_if.w_data}, {1'b1, 64'h11});
        s_if.w_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            acc = m_if.w_valid & m_if.w_ready;
            if (s_if.w_valid) begin
                check("w_bp_data", s_if.w_data, wd[got]);
                check("w_bp_strb", s_if.w_strb, ws[got]);
                got++;
            end
            tick();
            if (acc) m_if.w_valid = 1'b0;
        end
        check("w_bp_count", got, 4);
        check("w_bp_drained", s_if.w_valid, 0);

        // Wrap and simultaneous push/pop on the 3-deep R FIFO
        cnt = 0; sent = 0; recv = 0;
        for (int c = 0; c < 400 && recv < 20; c++) begin
            if (!s_if.r_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
                s_if.r_valid = 1'b1;
                s_if.r_data  = 64'hA5A5_0000_0000_0000 | 64'(sent);
                s_if.r_resp  = 2'(sent);
            end
            m_if.r_ready = 1'($urandom_range(0, 1));
            #1;
            check("r_valid_vs_model", m_if.r_valid, (cnt != 0));
            check("r_ready_vs_model", s_if.r_ready, (cnt != 3));
            push = s_if.r_valid && (cnt != 3);
            pop  = (cnt != 0) && m_if.r_ready;
            if (pop) begin
                check("r_data_order", {m_if.r_data, 62'(0), m_if.r_resp},
                      {64'hA5A5_0000_0000_0000 | 64'(recv), 62'(0), 2'(recv)});
                recv++;
            end
            @(posedge clk);
            #1;
            cnt = cnt + int'(push) - int'(pop);
            if (push) begin
                sent++;
                s_if.r_valid = 1'b0;
            end
        end
        check("r_beats", recv, 20);
        m_if.r_ready = 1'b1;
        tick();
        check("r_idle", idle, 1);

        // Half-rate: 1-deep B accepts every other cycle
        s_if.b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_if.b_resp = 2'(k);
            check("b_hr_ready_on", s_if.b_ready, 1);
            tick();
            check("b_hr_resp", {m_if.b_valid, m_if.b_resp}, {1'b1, 2'(k)});
            check("b_hr_ready_off", s_if.b_ready, 0);
            tick();
            check("b_hr_popped", m_if.b_valid, 0);
        end
        s_if.b_valid = 1'b0;
        tick();

        // Bypass: 0-deep AR is a wire in both directions
        for (int i = 0; i < 4; i++) begin
            m_if.ar_valid = ar_tab[i].valid;
            m_if.ar_addr  = ar_tab[i].addr;
            m_if.ar_prot  = ar_tab[i].prot;
            s_if.ar_ready = ar_tab[i].s_ready;
            #1;
            check("ar_byp_valid", s_if.ar_valid, ar_tab[i].exp_valid);
            check("ar_byp_payload", {s_if.ar_addr, s_if.ar_prot}, {ar_tab[i].exp_addr, ar_tab[i].exp_prot});
            check("ar_byp_ready", m_if.ar_ready, ar_tab[i].exp_ready);
            check("ar_byp_idle", idle, 1);
        end
        m_if.ar_valid = 1'b0;
        s_if.ar_ready = 1'b1;
        tick();

        // Reset in the middle of a stalled AW burst
        s_if.aw_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_if.aw_valid = 1'b1;
            m_if.aw_addr  = 48'h100 + 48'(8 * k);
            m_if.aw_prot  = '0;
            check("aw_rst_fill_ready", m_if.aw_ready, (k < 2));
            tick();
        end
        check("aw_rst_head", {s_if.aw_valid, s_if.aw_addr}, {1'b1, 48'h100});
        check("aw_rst_busy", idle, 0);
        #3;
        rst = 1'b1;
        #1;
        check("aw_rst_valid_drop", s_if.aw_valid, 0);
        check("aw_rst_ready_up", m_if.aw_ready, 1);
        check("aw_rst_idle", idle, 1);
        m_if.aw_valid = 1'b0;
        tick();
        tick();
        #3;
        rst = 1'b0;
        tick();
        s_if.aw_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("aw_rst_no_stale", s_if.aw_valid, 0);
            check("aw_rst_idle_after", idle, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
